// File: rtl/aukv_alu_arb.sv
// Two-requester arbiter for one shared combinational ALU. Holds one result until the owner accepts it.
// Latency 1 cycle; an unaccepted result blocks new grants. A handshake and a new grant can share a cycle.
module aukv_alu_arb #(
    parameter int FAIR = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [3:0]  i_req0_op,
    input  logic [3:0]  i_req1_op,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    input  logic        i_rsp0_ready,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp0_data,
    output logic [31:0] o_rsp1_data,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_alu_rs1,
    output logic [31:0] o_alu_rs2,
    input  logic [31:0] i_alu_rd,
    output logic        o_busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state;
    logic        owner;
    logic        last;
    logic [31:0] result;

    logic hs0, hs1, can_grant, pick1, gnt0, gnt1;

    assign hs0 = (state == HOLD) && !owner && i_rsp0_ready;
    assign hs1 = (state == HOLD) &&  owner && i_rsp1_ready;

    // Reset gating keeps ready and ALU outputs low while i_rst is held.
    assign can_grant = !i_rst && ((state == IDLE) || hs0 || hs1);

    // Tie-break: round-robin favours the requester not granted last.
    assign pick1 = (FAIR != 0) ? !last : 1'b0;

    assign gnt0 = can_grant && i_req0_valid && (!i_req1_valid || !pick1);
    assign gnt1 = can_grant && i_req1_valid && (!i_req0_valid ||  pick1);

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    always_comb begin
        o_alu_op  = 4'd0;
        o_alu_rs1 = 32'd0;
        o_alu_rs2 = 32'd0;
        if (gnt0) begin
            o_alu_op  = i_req0_op;
            o_alu_rs1 = i_req0_a;
            o_alu_rs2 = i_req0_b;
        end else if (gnt1) begin
            o_alu_op  = i_req1_op;
            o_alu_rs1 = i_req1_a;
            o_alu_rs2 = i_req1_b;
        end
    end

    assign o_busy       = (state == HOLD);
    assign o_rsp0_valid = (state == HOLD) && !owner;
    assign o_rsp1_valid = (state == HOLD) &&  owner;
    assign o_rsp0_data  = o_rsp0_valid ? result : 32'd0;
    assign o_rsp1_data  = o_rsp1_valid ? result : 32'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            result <= 32'd0;
        end else if (gnt0 || gnt1) begin
            state  <= HOLD;
            owner  <= gnt1;
            last   <= gnt1;
            result <= i_alu_rd;
        end else if (hs0 || hs1) begin
            state  <= IDLE;
        end
    end

endmodule

// File: tb/tb_aukv_alu_arb.sv
// Directed bench for aukv_alu_arb: a round-robin instance is scoreboarded; a fixed-priority
// instance shares the request inputs to check its tie-break.
module tb_aukv_alu_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_data, rsp1_data, alu_rs1, alu_rs2, alu_rd;
    logic [3:0]  alu_op;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [31:0] fp_rsp0_data, fp_rsp1_data, fp_alu_rs1, fp_alu_rs2, fp_alu_rd;
    logic [3:0]  fp_alu_op;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a | b;
            4'd3:    alu = a & b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << b[4:0];
            4'd6:    alu = $signed(a) >>> b[4:0];
            4'd7:    alu = a >> b[4:0];
            default: alu = 32'd0;
        endcase
    endfunction

    always_comb alu_rd    = alu(alu_op, alu_rs1, alu_rs2);
    always_comb fp_alu_rd = alu(fp_alu_op, fp_alu_rs1, fp_alu_rs2);

    aukv_alu_arb #(.FAIR(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
        .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
        .i_req0_op(req0_op), .i_req1_op(req1_op),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready),
        .o_rsp0_data(rsp0_data), .o_rsp1_data(rsp1_data),
        .o_alu_op(alu_op), .o_alu_rs1(alu_rs1), .o_alu_rs2(alu_rs2),
        .i_alu_rd(alu_rd), .o_busy(busy)
    );

    aukv_alu_arb #(.FAIR(0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
        .o_req0_ready(fp_req0_ready), .o_req1_ready(fp_req1_ready),
        .i_req0_op(req0_op), .i_req1_op(req1_op),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(fp_rsp0_valid), .o_rsp1_valid(fp_rsp1_valid),
        .i_rsp0_ready(1'b1), .i_rsp1_ready(1'b1),
        .o_rsp0_data(fp_rsp0_data), .o_rsp1_data(fp_rsp1_data),
        .o_alu_op(fp_alu_op), .o_alu_rs1(fp_alu_rs1), .o_alu_rs2(fp_alu_rs2),
        .i_alu_rd(fp_alu_rd), .o_busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic id, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got id=%0d data=0x%08h expected no response (t=%0t)", id, d, $time);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", {31'd0, id}, {31'd0, e.id});
            chk("rsp_data", d, e.data);
        end
    endtask

    // Monitor: consumes responses on every completed handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_data);
            if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_data);
            if (!rsp0_valid) chk("rsp0_data_idle", rsp0_data, 32'd0);
            if (!rsp1_valid) chk("rsp1_data_idle", rsp1_data, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd10; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'd5; req1_a = 32'd1;  req1_b = 32'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state, with both requests already presented.
        #12;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        chk("rst_alu_rs2", alu_rs2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie: round-robin alternates 0,1,0,1; fixed priority always picks 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tie_ready0", {31'd0, req0_ready}, {31'd0, ~k[0]});
            chk("tie_ready1", {31'd0, req1_ready}, {31'd0, k[0]});
            chk("tie_alu_op", {28'd0, alu_op}, k[0] ? 32'd5 : 32'd1);
            chk("fp_ready0", {31'd0, fp_req0_ready}, 32'd1);
            chk("fp_ready1", {31'd0, fp_req1_ready}, 32'd0);
            if (k > 0) begin
                chk("tie_busy", {31'd0, busy}, 32'd1);
                chk("tie_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, k[0]});
            end
            push(k[0], k[0] ? 32'd16 : 32'd7);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("tie_last_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("tie_idle_busy", {31'd0, busy}, 32'd0);

        // Single op: 5 + 7.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        chk("single_rs1", alu_rs1, 32'd5);
        chk("single_rs2", alu_rs2, 32'd7);
        push(1'b0, 32'd12);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("single_rsp0_data", rsp0_data, 32'd12);
        @(negedge clk);
        chk("single_busy_after", {31'd0, busy}, 32'd0);

        // Stall: req1 sra held while consumer is not ready.
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'h8000_0000; req1_b = 32'd4;
        @(negedge clk);
        chk("stall_grant1", {31'd0, req1_ready}, 32'd1);
        push(1'b1, 32'hF800_0000);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1;    req0_b = 32'd2;
        req1_op    = 4'd2; req1_a  = 32'hF0; req1_b = 32'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("stall_rsp1_data", rsp1_data, 32'hF800_0000);
            chk("stall_ready0", {31'd0, req0_ready}, 32'd0);
            chk("stall_ready1", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("release_ready0", {31'd0, req0_ready}, 32'd1);
        chk("release_ready1", {31'd0, req1_ready}, 32'd0);
        push(1'b0, 32'd3);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("release_ready1_next", {31'd0, req1_ready}, 32'd1);
        push(1'b1, 32'hFF);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_idle_busy", {31'd0, busy}, 32'd0);

        // Reset while holding a result that is never consumed.
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'hFF; req0_b = 32'h0F;
        @(negedge clk);
        chk("rsthold_grant0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rsthold_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("rsthold_rsp0_data", rsp0_data, 32'hF0);
        #2;
        rst = 1'b1;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        chk("rsthold_async_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rsthold_async_data", rsp0_data, 32'd0);
        chk("rsthold_async_busy", {31'd0, busy}, 32'd0);
        chk("rsthold_async_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rsthold_async_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rsthold_async_rs1", alu_rs1, 32'd0);
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
            chk("postrst_busy", {31'd0, busy}, 32'd0);
        end

        // Unknown op, granted on the first edge after reset release.
        #2;
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd9; req0_a = 32'd3; req0_b = 32'd4;
        @(posedge clk); #1;
        chk("inv_ready_in_rst", {31'd0, req0_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("inv_ready0", {31'd0, req0_ready}, 32'd1);
        chk("inv_alu_op", {28'd0, alu_op}, 32'd9);
        push(1'b0, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("inv_busy", {31'd0, busy}, 32'd1);
        chk("inv_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("inv_rsp0_data", rsp0_data, 32'd0);

        // Every expected response must have been seen.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aukv_alu_arb.md
AUKV_ALU_ARB -- requirements
Module: aukv_alu_arb

Interface
REQ-001 Parameter FAIR, default 1, SHALL select the arbitration policy: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 i_req0_valid / i_req1_valid  input  1 each  SHALL each flag that the requester presents an operation.
REQ-005 o_req0_ready / o_req1_ready  output  1 each  SHALL each flag that the requester's operation is accepted this cycle.
REQ-006 i_req0_op / i_req1_op  input  4 each  SHALL carry the ALU operation code: 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 sll, 6 sra, 7 srl.
REQ-007 i_req0_a, i_req0_b, i_req1_a, i_req1_b  input  32 each  SHALL carry the operands.
REQ-008 o_rsp0_valid / o_rsp1_valid  output  1 each  SHALL each flag that a result is available for that requester.
REQ-009 i_rsp0_ready / i_rsp1_ready  input  1 each  SHALL each flag that the requester consumes its result.
REQ-010 o_rsp0_data / o_rsp1_data  output  32 each  SHALL carry the result.
REQ-011 o_alu_op  output  4  SHALL drive the operation to the shared combinational ALU.
REQ-012 o_alu_rs1 / o_alu_rs2  output  32 each  SHALL drive the ALU operands.
REQ-013 i_alu_rd  input  32  SHALL return the ALU result in the same cycle.
REQ-014 o_busy  output  1  SHALL be high whenever a result is held.

Function
REQ-015 The block SHALL have two states: IDLE (no result held) and HOLD (one result held for owner 0 or 1).
REQ-016 The block SHALL be able to grant when in IDLE, or when in HOLD with the owner's response handshake (o_rspX_valid and i_rspX_ready) completing this cycle.
REQ-017 When able to grant with exactly one valid request, the block SHALL grant that request.
REQ-018 When able to grant with both requests valid:
- FAIR=1: the requester not granted last SHALL win.
- FAIR=0: requester 0 SHALL win.
REQ-019 A last-granted pointer SHALL update only on a grant, and SHALL reset to 1 so that requester 0 wins the first tie.
REQ-020 o_reqX_ready SHALL be high only in the cycle requester X is granted; it SHALL be combinational from the valids, the state and i_rspX_ready.
REQ-021 In a grant cycle, o_alu_op, o_alu_rs1 and o_alu_rs2 SHALL equal the winner's op, a and b; in all other cycles they SHALL be 0.
REQ-022 On a grant edge:
- i_alu_rd SHALL be registered into the result register.
- The owner SHALL be set to the winner.
- The state SHALL become HOLD.
REQ-023 Latency SHALL be 1 cycle: a result accepted at edge N SHALL give o_rspX_valid = 1 in cycle N+1.
REQ-024 o_rspX_valid SHALL be high only when state = HOLD and owner = X; the other requester's valid SHALL be 0.
REQ-025 o_rspX_data SHALL equal the result register when o_rspX_valid is high, and SHALL be 0 otherwise.
REQ-026 Held data SHALL remain stable until the response handshake completes; a stalled consumer SHALL block new grants.
REQ-027 On handshake with no new grant, the state SHALL return to IDLE.
REQ-028 On handshake with a simultaneous grant, the state SHALL stay HOLD with the new owner and result, with no bubble.
REQ-029 An op code of 8-15 SHALL be passed through unchanged, and the ALU result (0) SHALL be returned as a normal response.
REQ-030 The block SHALL NOT drop, reorder or duplicate a request; at most one result SHALL be outstanding.
REQ-031 A requester deasserting valid before being granted SHALL be permitted and SHALL have no side effects.

Reset
REQ-032 While i_rst = 1, the block SHALL asynchronously reset as follows:
- State = IDLE, owner = 0, pointer = 1, result register = 0.
- All ready/valid outputs = 0; o_busy = 0.
- All data and ALU outputs = 0.
REQ-033 Reset asserted during HOLD SHALL discard the held result, with no response issued after release.
REQ-034 The first grant SHALL be possible in the first clock edge after i_rst deasserts.

Verification
REQ-035 Single op: req0 op=0, a=5, b=7, rsp0_ready=1 -> ready0 in cycle 0; rsp0_valid=1 with data=12 in cycle 1; o_busy=0 in cycle 2.
REQ-036 Tie, FAIR=1: both valid continuously; req0 op=1 a=10 b=3, req1 op=5 a=1 b=4, rsp ready=1 -> grants alternate 0,1,0,1; responses 7, 16, 7, 16 back-to-back with no idle cycle.
REQ-037 Tie, FAIR=0: both valid for 4 cycles -> req0 granted every opportunity; req1 never granted.
REQ-038 Stall: rsp1_ready=0 for 5 cycles while holding req1 op=6 a=0x80000000 b=4 -> data stable at 0xF8000000; ready0 and ready1 stay 0; grant resumes in the release cycle.
REQ-039 Reset in HOLD: assert i_rst while holding -> all outputs 0 immediately; after release, no response appears without a new request.
REQ-040 Invalid op: req0 op=9 -> o_alu_op=9 in the grant cycle; rsp0_data=0 in the next cycle.
